// File: rtl/dmem_port.sv
// Data-memory access port: latches an address/data request from the register
// file and runs a request/grant/response handshake with the shared arbiter.
//   state | meaning
//   IDLE  | waiting for MEMRD/MEMWR
//   REQ   | mem_req asserted, waiting for grant
//   WAIT  | read granted, waiting for rvalid
//   DONE  | one-cycle completion, MEMDONE high
module dmem_port #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEMRD,
  input  logic              MEMWR,
  input  logic [ADDR_W-1:0] DMADDR,
  input  logic [DATA_W-1:0] DOUT,
  output logic [DATA_W-1:0] DIN,
  output logic              MEMBUSY,
  output logic              MEMDONE,
  output logic              MEMERR,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state, state_n;
  logic [7:0]        cnt, cnt_n;
  logic [DATA_W-1:0] din_n;
  logic              err_n;
  logic              we_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      DIN       <= '0;
      MEMBUSY   <= 1'b0;
      MEMDONE   <= 1'b0;
      MEMERR    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      DIN       <= din_n;
      MEMERR    <= err_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      // Handshake outputs are decoded from the next state so they are registered.
      mem_req   <= (state_n == REQ);
      MEMBUSY   <= (state_n == REQ) || (state_n == WAIT);
      MEMDONE   <= (state_n == DONE);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    din_n   = DIN;
    err_n   = MEMERR;
    we_n    = mem_we;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (MEMRD || MEMWR) begin
          addr_n  = DMADDR;
          wdata_n = DOUT;
          // A simultaneous read and write resolves to a read.
          we_n    = MEMWR & ~MEMRD;
          state_n = REQ;
        end
      end
      REQ: begin
        if (mem_gnt && mem_we) begin
          state_n = DONE;
        end else if (mem_gnt && mem_rvalid) begin
          din_n   = mem_rdata;
          state_n = DONE;
        end else if (mem_gnt) begin
          cnt_n   = '0;
          state_n = WAIT;
        end else if (cnt == CNT_LAST) begin
          err_n   = 1'b1;
          din_n   = '1;
          state_n = DONE;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          din_n   = mem_rdata;
          state_n = DONE;
        end else if (cnt == CNT_LAST) begin
          err_n   = 1'b1;
          din_n   = '1;
          state_n = DONE;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      DONE: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_port.sv
// Self-checking bench for dmem_port: directed vector table, randomized
// transactions against a transaction-level model, and a reset-in-WAIT sequence.
module tb_dmem_port;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          MEMRD, MEMWR;
  logic [AW-1:0] DMADDR;
  logic [DW-1:0] DOUT;
  logic [DW-1:0] DIN;
  logic          MEMBUSY, MEMDONE, MEMERR;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt, mem_rvalid;
  logic [DW-1:0] mem_rdata;

  dmem_port #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .MEMRD(MEMRD), .MEMWR(MEMWR), .DMADDR(DMADDR), .DOUT(DOUT),
    .DIN(DIN), .MEMBUSY(MEMBUSY), .MEMDONE(MEMDONE), .MEMERR(MEMERR),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          g;        // grant sampled at the g-th REQ cycle
    int          r;        // rvalid r cycles after the grant cycle
    logic [15:0] rdata;
    logic        exp_we;
    int          exp_busy;
    logic [15:0] exp_din;
    logic        exp_err;
  } vec_t;

  vec_t tbl[8];

  // Drives one transaction with noise on the request inputs while busy.
  task automatic run_txn(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input int g, input int r,
                         input logic [15:0] rdata, input logic exp_we,
                         output int busy, output int dones, output int latch_bad,
                         output bit spawned, output bit timed_out);
    bit seen_done;
    seen_done = 0;
    busy = 0; dones = 0; latch_bad = 0; spawned = 0; timed_out = 1;
    @(negedge clk);
    MEMRD = rd; MEMWR = wr; DMADDR = addr; DOUT = wdata;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = rdata;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (MEMBUSY) busy++;
      if (MEMDONE) dones++;
      if (mem_req && (mem_addr !== addr || mem_we !== exp_we || mem_wdata !== wdata))
        latch_bad++;
      if (seen_done) begin
        spawned = MEMBUSY | mem_req | MEMDONE;
        timed_out = 0;
        break;
      end
      if (MEMDONE) seen_done = 1;
      if (MEMBUSY || MEMDONE) begin
        MEMRD  = 1'($urandom_range(0, 1));
        MEMWR  = 1'($urandom_range(0, 1));
        DMADDR = 16'($urandom);
        DOUT   = 16'($urandom);
      end else begin
        MEMRD = 0; MEMWR = 0;
      end
      mem_gnt    = (n == g);
      mem_rvalid = rd && (n == g + r);
    end
    MEMRD = 0; MEMWR = 0; mem_gnt = 0; mem_rvalid = 0;
  endtask

  // Transaction-level outcome from the port's rules.
  task automatic model(input bit rd, input int g, input int r, input logic [15:0] rdata,
                       inout logic [15:0] din, inout logic err, output int busy);
    if (g > TO) begin
      busy = TO; din = 16'hFFFF; err = 1;
    end else if (!rd) begin
      busy = g;
    end else if (r == 0) begin
      busy = g; din = rdata;
    end else if (r > TO) begin
      busy = g + TO; din = 16'hFFFF; err = 1;
    end else begin
      busy = g + r; din = rdata;
    end
  endtask

  task automatic do_and_check(input string tag, input logic rd, input logic wr,
                              input logic [15:0] addr, input logic [15:0] wdata,
                              input int g, input int r, input logic [15:0] rdata,
                              input logic exp_we, input int exp_busy,
                              input logic [15:0] exp_din, input logic exp_err);
    int busy, dones, bad;
    bit spawned, tmo;
    run_txn(rd, wr, addr, wdata, g, r, rdata, exp_we, busy, dones, bad, spawned, tmo);
    check({tag, " no_timeout"}, 32'(tmo), 32'd0);
    check({tag, " latched"}, 32'(bad), 32'd0);
    check({tag, " busy_cycles"}, 32'(busy), 32'(exp_busy));
    check({tag, " done_pulses"}, 32'(dones), 32'd1);
    check({tag, " no_respawn"}, 32'(spawned), 32'd0);
    check({tag, " DIN"}, 32'(DIN), 32'(exp_din));
    check({tag, " MEMERR"}, 32'(MEMERR), 32'(exp_err));
  endtask

  initial begin
    logic [15:0] mdin;
    logic        merr;
    int          ebusy;
    int          bad;
    logic        rd, wr;
    int          g, r;
    logic [15:0] a, d, rdt;

    tbl[0] = '{1, 0, 16'h0040, 16'h0000, 3, 2,  16'hBEEF, 0, 5,  16'hBEEF, 0};
    tbl[1] = '{0, 1, 16'h0100, 16'h1234, 1, 0,  16'h0000, 1, 1,  16'hBEEF, 0};
    tbl[2] = '{1, 1, 16'h0200, 16'h5555, 2, 1,  16'h1357, 0, 3,  16'h1357, 0};
    tbl[3] = '{1, 0, 16'h0300, 16'h0000, 70, 0, 16'h0000, 0, 64, 16'hFFFF, 1};
    tbl[4] = '{1, 0, 16'h0044, 16'h0000, 2, 3,  16'h2468, 0, 5,  16'h2468, 1};
    tbl[5] = '{1, 0, 16'h0050, 16'h0000, 1, 0,  16'h00A5, 0, 1,  16'h00A5, 1};
    tbl[6] = '{0, 1, 16'h0060, 16'hABCD, 4, 0,  16'h0000, 1, 4,  16'h00A5, 1};
    tbl[7] = '{1, 0, 16'h0070, 16'h0000, 2, 65, 16'h7777, 0, 66, 16'hFFFF, 1};

    rst = 1; MEMRD = 0; MEMWR = 0; DMADDR = '0; DOUT = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    check("reset DIN", 32'(DIN), 32'd0);
    check("reset MEMBUSY", 32'(MEMBUSY), 32'd0);
    check("reset MEMDONE", 32'(MEMDONE), 32'd0);
    check("reset MEMERR", 32'(MEMERR), 32'd0);
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset mem_we/addr/wdata", {15'd0, mem_we, mem_addr}, 32'd0);
    check("reset wdata", 32'(mem_wdata), 32'd0);
    @(negedge clk);
    check("idle no req", 32'(mem_req), 32'd0);

    for (int i = 0; i < 8; i++)
      do_and_check($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata,
                   tbl[i].g, tbl[i].r, tbl[i].rdata, tbl[i].exp_we, tbl[i].exp_busy,
                   tbl[i].exp_din, tbl[i].exp_err);

    mdin = 16'hFFFF;
    merr = 1;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 2))
        0: begin rd = 1; wr = 0; end
        1: begin rd = 0; wr = 1; end
        default: begin rd = 1; wr = 1; end
      endcase
      g   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 70)) : int'($urandom_range(1, 6));
      r   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(62, 66)) : int'($urandom_range(0, 4));
      a   = 16'($urandom);
      d   = 16'($urandom);
      rdt = 16'($urandom);
      model(rd, g, r, rdt, mdin, merr, ebusy);
      do_and_check($sformatf("rnd%0d", i), rd, wr, a, d, g, r, rdt, wr & ~rd,
                   ebusy, mdin, merr);
    end

    // Reset while waiting for read data; a late rvalid must be ignored.
    @(negedge clk);
    MEMRD = 1; DMADDR = 16'h0777; DOUT = 16'h4321;
    @(negedge clk);
    MEMRD = 0; mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    check("rstwait in WAIT", {30'd0, MEMBUSY, mem_req}, 32'h2);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("rstwait DIN", 32'(DIN), 32'd0);
    check("rstwait MEMBUSY", 32'(MEMBUSY), 32'd0);
    check("rstwait MEMDONE", 32'(MEMDONE), 32'd0);
    check("rstwait MEMERR", 32'(MEMERR), 32'd0);
    check("rstwait mem_req", 32'(mem_req), 32'd0);
    check("rstwait mem_we", 32'(mem_we), 32'd0);
    check("rstwait mem_addr", 32'(mem_addr), 32'd0);
    check("rstwait mem_wdata", 32'(mem_wdata), 32'd0);
    mem_rvalid = 1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    mem_rvalid = 0;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (MEMDONE || MEMBUSY || DIN !== 16'h0000) bad++;
      @(negedge clk);
    end
    check("rstwait late rvalid ignored", 32'(bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
